// File: rtl/dma_xfer_ctrl.sv
// Single-channel DMA transfer sequencer.
// Copies a configured number of 32-bit words from a source to a destination
// address. Each word is a read phase followed by a write phase on the
// downstream register-interface master. It reports busy, done and error status.
module dma_xfer_ctrl #(
  parameter int LEN_W       = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      cfg_src,
  input  logic [31:0]      cfg_dst,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_src_inc,
  input  logic             cfg_dst_inc,
  input  logic             start,
  input  logic             abort,
  output logic [31:0]      dma_addr,
  output logic             dma_read,
  output logic [31:0]      write_data,
  input  logic [31:0]      reg_data_i,
  input  logic             ready_i,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [LEN_W-1:0] words_left
);

  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [2:0] {
    IDLE, RD_ARM, RD_WAIT, WR_ARM, WR_WAIT, DONE, ERR
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       src_ptr_q, src_ptr_d;
  logic [31:0]       dst_ptr_q, dst_ptr_d;
  logic              src_inc_q, src_inc_d;
  logic              dst_inc_q, dst_inc_d;
  logic [LEN_W-1:0]  words_left_q, words_left_d;
  logic [31:0]       addr_q, addr_d;
  logic              read_q, read_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              timeout_hit;

  assign dma_addr   = addr_q;
  assign dma_read   = read_q;
  assign write_data = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign words_left = words_left_q;

  // A waiting phase gives up once the timer has seen TIMEOUT_CYC cycles without
  // ready. A zero TIMEOUT_CYC disables the check.
  assign timeout_hit = (TIMEOUT_CYC != 0) &&
                       (32'(timer_q) == 32'(TIMEOUT_CYC - 1));

  // Sequencing: the next state and the next register values, including the bus
  // outputs that are loaded on entry to each ARM state and then held.
  always_comb begin
    state_d      = state_q;
    src_ptr_d    = src_ptr_q;
    dst_ptr_d    = dst_ptr_q;
    src_inc_d    = src_inc_q;
    dst_inc_d    = dst_inc_q;
    words_left_d = words_left_q;
    addr_d       = addr_q;
    read_d       = read_q;
    wdata_d      = wdata_q;
    error_d      = error_q;
    timer_d      = timer_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          src_ptr_d    = cfg_src;
          dst_ptr_d    = cfg_dst;
          words_left_d = cfg_len;
          src_inc_d    = cfg_src_inc;
          dst_inc_d    = cfg_dst_inc;
          error_d      = 1'b0;
          state_d      = (cfg_len == '0) ? DONE : RD_ARM;
        end
      end
      RD_ARM:  state_d = RD_WAIT;
      RD_WAIT: begin
        if (ready_i) begin
          wdata_d = reg_data_i;
          state_d = WR_ARM;
        end else if (timeout_hit) begin
          state_d = ERR;
        end
      end
      WR_ARM:  state_d = WR_WAIT;
      WR_WAIT: begin
        if (ready_i) begin
          words_left_d = words_left_q - LEN_W'(1);
          if (src_inc_q) src_ptr_d = src_ptr_q + 32'd4;
          if (dst_inc_q) dst_ptr_d = dst_ptr_q + 32'd4;
          state_d = ((words_left_d == '0) || abort) ? DONE : RD_ARM;
        end else if (timeout_hit) begin
          state_d = ERR;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      timer_d = '0;
    end else if ((state_q == RD_WAIT || state_q == WR_WAIT) && (TIMEOUT_CYC != 0)) begin
      timer_d = timer_q + TMR_W'(1);
    end

    if (state_d == RD_ARM && state_q != RD_ARM) begin
      addr_d = src_ptr_d;
      read_d = 1'b1;
    end else if (state_d == WR_ARM && state_q != WR_ARM) begin
      addr_d = dst_ptr_q;
      read_d = 1'b0;
    end

    if (state_d == ERR) error_d = 1'b1;

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and output registers. Reset is asynchronous and drops any transfer
  // in progress without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      src_ptr_q    <= '0;
      dst_ptr_q    <= '0;
      src_inc_q    <= 1'b0;
      dst_inc_q    <= 1'b0;
      words_left_q <= '0;
      addr_q       <= '0;
      read_q       <= 1'b1;
      wdata_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      src_ptr_q    <= src_ptr_d;
      dst_ptr_q    <= dst_ptr_d;
      src_inc_q    <= src_inc_d;
      dst_inc_q    <= dst_inc_d;
      words_left_q <= words_left_d;
      addr_q       <= addr_d;
      read_q       <= read_d;
      wdata_q      <= wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      timer_q      <= timer_d;
    end
  end

endmodule
